// File: rtl/uart_link_if.sv
// Serial-side and byte-side signals of uart_link grouped into one bundle.
// The slave modport is the UART itself; master is the producer/consumer side.
interface uart_link_if;
  logic       rxd;
  logic       txd;
  logic [7:0] rxdata;
  logic       rxfinish;
  logic       frame_err;
  logic [7:0] txdata;
  logic       send;
  logic       txdone;
  logic       tx_busy;

  modport slave (
    input  rxd, txdata, send,
    output txd, rxdata, rxfinish, frame_err, txdone, tx_busy
  );

  modport master (
    output rxd, txdata, send,
    input  txd, rxdata, rxfinish, frame_err, txdone, tx_busy
  );
endinterface

// File: rtl/uart_link.sv
// 8N1 UART with independent RX and TX engines sharing only the clock.
// RX samples mid-bit after a half-bit start qualification; TX adds a 2-cycle guard after stop.
module uart_link #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  uart_link_if.slave  io_bus
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_GUARD} tx_state_t;

  // ---------------- RX ----------------
  logic [1:0]  r_rx_sync;
  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_idx, w_rx_idx_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic [7:0]  r_rxdata, w_rxdata_nxt;
  logic        r_rxfinish, w_rxfinish_nxt;
  logic        r_frame_err, w_frame_err_nxt;
  logic        w_rx;
  logic        w_rx_bit_end;

  assign w_rx         = r_rx_sync[1];
  assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);

  // Synchronizer idles high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) r_rx_sync <= 2'b11;
    else     r_rx_sync <= {r_rx_sync[0], io_bus.rxd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_idx    <= '0;
      r_rx_shift  <= '0;
      r_rxdata    <= '0;
      r_rxfinish  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_state_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_rx_idx    <= w_rx_idx_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rxdata    <= w_rxdata_nxt;
      r_rxfinish  <= w_rxfinish_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt  = r_rx_state;
    w_rx_cnt_nxt    = r_rx_cnt;
    w_rx_idx_nxt    = r_rx_idx;
    w_rx_shift_nxt  = r_rx_shift;
    w_rxdata_nxt    = r_rxdata;
    w_rxfinish_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rx) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
          w_rx_idx_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {w_rx, r_rx_shift[7:1]};
          w_rx_idx_nxt   = r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_nxt = '0;
          if (w_rx) begin
            w_rxdata_nxt   = r_rx_shift;
            w_rxfinish_nxt = 1'b1;
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_rx_state_nxt  = RX_WAIT;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 16'd1;
        end
      end
      // A stuck-low line after a bad stop must not be mistaken for a new start bit.
      RX_WAIT: begin
        if (w_rx) w_rx_state_nxt = RX_IDLE;
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
        w_rx_cnt_nxt   = '0;
      end
    endcase
  end

  assign io_bus.rxdata    = r_rxdata;
  assign io_bus.rxfinish  = r_rxfinish;
  assign io_bus.frame_err = r_frame_err;

  // ---------------- TX ----------------
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]  r_tx_idx, w_tx_idx_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic        w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    case (r_tx_state)
      TX_IDLE: begin
        if (io_bus.send) begin
          w_tx_shift_nxt = io_bus.txdata;
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt = '0;
          w_tx_idx_nxt = r_tx_idx + 3'd1;
          if (r_tx_idx == 3'd7) w_tx_state_nxt = TX_STOP;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_GUARD;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      // Two idle-high cycles so a producer holding send can swap txdata.
      TX_GUARD: begin
        if (r_tx_cnt == 16'd1) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 16'd1;
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_cnt_nxt   = '0;
      end
    endcase
  end

  assign io_bus.txd     = (r_tx_state == TX_START) ? 1'b0 :
                          (r_tx_state == TX_DATA)  ? r_tx_shift[r_tx_idx] : 1'b1;
  assign io_bus.txdone  = !rst && (r_tx_state == TX_STOP) && w_tx_bit_end;
  assign io_bus.tx_busy = (r_tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_link.sv
// Randomized bench for uart_link at 16 clocks/bit; outputs are logged per cycle
// and compared against frame timing derived from the 8N1 rules.
module tb_uart_link;
  localparam int CPB  = 16;
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  uart_link_if bus();

  uart_link #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       txd_log  [0:LOGN-1];
  logic       busy_log [0:LOGN-1];
  int         td_q[$];
  int         rf_c[$];
  logic [7:0] rf_d[$];
  int         fe_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle log of DUT outputs, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      txd_log[cyc]  = bus.txd;
      busy_log[cyc] = bus.tx_busy;
    end
    if (bus.txdone) td_q.push_back(cyc);
    if (bus.rxfinish) begin
      rf_c.push_back(cyc);
      rf_d.push_back(bus.rxdata);
    end
    if (bus.frame_err) fe_q.push_back(cyc);
    if (bus.rxfinish || bus.frame_err) chk("rx_excl", 32'(bus.rxfinish & bus.frame_err), 0);
  end

  function automatic int n_ev(input int which, input int lo, input int hi);
    int n = 0;
    if (which == 0) begin foreach (td_q[i]) if (td_q[i] >= lo && td_q[i] <= hi) n++; end
    else if (which == 1) begin foreach (rf_c[i]) if (rf_c[i] >= lo && rf_c[i] <= hi) n++; end
    else begin foreach (fe_q[i]) if (fe_q[i] >= lo && fe_q[i] <= hi) n++; end
    return n;
  endfunction

  function automatic logic [7:0] rf_data_in(input int lo, input int hi);
    foreach (rf_c[i]) if (rf_c[i] >= lo && rf_c[i] <= hi) return rf_d[i];
    return 8'hEE;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc <= c) @(posedge clk);
    #1;
  endtask

  // Pulse send for one cycle while TX is idle; a = acceptance cycle.
  task automatic send_one(input logic [7:0] b, output int a);
    for (int k = 0; k < 400 && bus.tx_busy; k++) step();
    chk("tx_idle_wait", 32'(bus.tx_busy), 0);
    bus.txdata = b;
    bus.send   = 1'b1;
    a = cyc;
    step();
    bus.send = 1'b0;
  endtask

  task automatic rx_bit(input logic v);
    bus.rxd = v;
    repeat (CPB) step();
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, output int s);
    step();
    s = cyc;
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
  endtask

  // Frame accepted in cycle a: start bit in a+1..a+16, data LSB first, stop to a+160.
  task automatic tx_check(input string tag, input int a, input logic [7:0] b);
    logic [15:0] v;
    logic [15:0] e;
    wait_cyc(a + 165);
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 16; k++) v[k] = txd_log[a + 1 + s * CPB + k];
      e = (s == 0) ? 16'h0000 : (s == 9) ? 16'hFFFF : {16{b[s-1]}};
      chk($sformatf("%s_bit%0d", tag, s), 32'(v), 32'(e));
    end
    chk({tag, "_done_n"},  n_ev(0, a + 1, a + 162), 1);
    chk({tag, "_done_at"}, n_ev(0, a + 160, a + 160), 1);
    chk({tag, "_busy_on"}, 32'(busy_log[a + 1]), 1);
    chk({tag, "_busy_grd"}, 32'(busy_log[a + 162]), 1);
    chk({tag, "_busy_off"}, 32'(busy_log[a + 163]), 0);
  endtask

  task automatic rx_check(input string tag, input int s, input logic [7:0] b, input logic stop);
    wait_cyc(s + 170);
    if (stop) begin
      chk({tag, "_fin_n"}, n_ev(1, s, s + 166), 1);
      chk({tag, "_data"},  32'(rf_data_in(s, s + 166)), 32'(b));
      chk({tag, "_ferr_n"}, n_ev(2, s, s + 166), 0);
    end else begin
      chk({tag, "_fin_n"}, n_ev(1, s, s + 166), 0);
      chk({tag, "_ferr_n"}, n_ev(2, s, s + 166), 1);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a, a2, s, s2, t, seen;
    logic [7:0] btx, brx;
    logic stp;
    bus.rxd = 1'b1; bus.send = 1'b0; bus.txdata = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", 32'(bus.txd), 1);
    chk("rst_rxdata", 32'(bus.rxdata), 0);
    chk("rst_rxfinish", 32'(bus.rxfinish), 0);
    chk("rst_ferr", 32'(bus.frame_err), 0);
    chk("rst_txdone", 32'(bus.txdone), 0);
    chk("rst_busy", 32'(bus.tx_busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) step();

    send_one(8'hA5, a);
    tx_check("txA5", a, 8'hA5);

    rx_frame(8'h3C, 1'b1, s);
    rx_check("rx3C", s, 8'h3C, 1'b1);

    // Short low pulse must be rejected as a glitch
    step();
    s = cyc;
    bus.rxd = 1'b0;
    repeat (4) step();
    bus.rxd = 1'b1;
    wait_cyc(s + 40);
    chk("glitch_fin", n_ev(1, s, s + 40), 0);
    chk("glitch_ferr", n_ev(2, s, s + 40), 0);
    rx_frame(8'h81, 1'b1, s);
    rx_check("rx81", s, 8'h81, 1'b1);

    rx_frame(8'h3C, 1'b1, s);
    rx_check("rx3Cb", s, 8'h3C, 1'b1);
    rx_frame(8'h55, 1'b0, s);
    rx_check("ferr55", s, 8'h55, 1'b0);
    chk("ferr_keep", 32'(bus.rxdata), 32'h3C);
    // Line stays low: no new frame may start
    s2 = cyc;
    repeat (200) step();
    chk("wait_fin", n_ev(1, s2, cyc), 0);
    chk("wait_ferr", n_ev(2, s2, cyc), 0);
    bus.rxd = 1'b1;
    repeat (5) step();
    rx_frame(8'hC3, 1'b1, s);
    rx_check("rxC3", s, 8'hC3, 1'b1);

    // Reset during TX bit 3
    send_one(8'h70, a);
    while (cyc < a + 73) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    wait_cyc(a + 260);
    chk("rst_pre_bit3", 32'(txd_log[a + 73]), 0);
    chk("rst_txd_next", 32'(txd_log[a + 74]), 1);
    chk("rst_busy_next", 32'(busy_log[a + 74]), 0);
    chk("rst_no_done", n_ev(0, a + 73, a + 260), 0);
    chk("rst_rxdata_clr", 32'(bus.rxdata), 0);

    // Back-to-back with send held, concurrent RX of 0x00
    fork
      begin
        bus.txdata = 8'h12;
        bus.send   = 1'b1;
        a = cyc;
        seen = 0;
        t = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (bus.txdone) begin seen = 1; t = cyc; end
        end
        chk("b2b_done_seen", 32'(seen), 1);
        chk("b2b_done_cyc", t, a + 160);
        step();
        bus.txdata = 8'h34;
        while (cyc < a + 164) step();
        bus.send = 1'b0;
      end
      begin
        repeat (25) step();
        rx_frame(8'h00, 1'b1, s);
      end
    join
    tx_check("b2b12", a, 8'h12);
    tx_check("b2b34", a + 163, 8'h34);
    rx_check("rx00", s, 8'h00, 1'b1);

    // Random concurrent traffic
    for (int it = 0; it < 6; it++) begin
      btx = 8'($urandom);
      brx = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      fork
        begin repeat ($urandom_range(0, 40)) step(); send_one(btx, a2); end
        begin
          repeat ($urandom_range(0, 40)) step();
          rx_frame(brx, stp, s2);
          bus.rxd = 1'b1;
        end
      join
      tx_check($sformatf("rtx%0d", it), a2, btx);
      rx_check($sformatf("rrx%0d", it), s2, brx, stp);
      repeat (4) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
